digit_classifier_ctrl: RTL
==========================

# digit_classifier_ctrl

Row-sequencing controller that drives the `multiplier` block's row handshake for one full classification pass. On `start` it:
- issues `begin_mult` and `row_select` for weight rows 0..NUM_ROWS-1 in order;
- captures each 16-bit `row_result` when `done_row` pulses;
- stores every score;
- keeps a running argmax, reporting the winning row as the classified digit.

It sits between the top-level control FSM and the multiplier, on the initiator side of the row interface.

## Interface
- NUM_ROWS, 10, number of weight rows / output classes (max 16)
- TIMEOUT_CYCLES, 10'd1000, max cycles to wait for `done_row` after `begin_mult` before aborting
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous, active-low reset
- start  input  1  request a classification pass; sampled only in IDLE
- done_row  input  1  multiplier row-complete pulse
- row_result  input  16  multiplier row sum; valid while `done_row`=1
- score_sel  input  4  index of stored score to read back
- begin_mult  output  1  one-cycle pulse starting one row on the multiplier
- row_select  output  4  row under computation; held stable from `begin_mult` until `done_row` is captured
- busy  output  1  high from the cycle after `start` is accepted until return to IDLE
- class_done  output  1  one-cycle pulse when all rows are finished
- digit  output  4  index of the maximum score; held until the next accepted `start`
- max_score  output  16  value of the maximum score; held like `digit`
- error  output  1  sticky timeout flag; cleared on the next accepted `start`
- score_out  output  16  stored score[score_sel]; 0 if score_sel >= NUM_ROWS

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On `start`=1, go to ISSUE.
  - On the same edge: row <= 0, error <= 0, all stored scores <= 0.
- ISSUE:
  - begin_mult=1, row_select=row, timeout counter cleared.
  - Next state is always WAIT.
- WAIT:
  - begin_mult=0; the timeout counter increments each cycle.
  - If `done_row`=1:
    - score[row] <= row_result.
    - If row==0 or row_result > max_score (strictly greater): max_score <= row_result, digit <= row.
    - Ties therefore keep the lowest index.
    - If row==NUM_ROWS-1, go to DONE; otherwise row <= row+1 and go to ISSUE.
  - Else, if the counter reaches TIMEOUT_CYCLES: error <= 1, go to IDLE. `digit`, `max_score` and `class_done` are not updated.
  - `done_row` wins over timeout on the same cycle.
- DONE: class_done=1 for one cycle; next state is IDLE.
- Arithmetic:
  - Compare is unsigned 16-bit.
  - The row counter is 4 bits and never exceeds NUM_ROWS-1.
- Ignored inputs:
  - `start` is ignored in ISSUE, WAIT and DONE.
  - `done_row` is ignored outside WAIT.
- `score_out` is a combinational read of the score register file.

## Timing
- Reset values: state IDLE; begin_mult 0, row_select 0, busy 0, class_done 0, digit 0, max_score 0, error 0; all scores 0, so score_out 0.
- Reset mid-pass returns to IDLE immediately. No `class_done` is produced, and the multiplier is not otherwise signalled.
- Accept and issue sequence:
  - Cycle where `start`=1 in IDLE: edge E0.
  - After E0: ISSUE, begin_mult=1, busy=1.
  - After the next edge: WAIT.
- The ISSUE cycle that follows a captured `done_row` coincides with the multiplier's own return to idle, so back-to-back rows lose no cycles.
- Pass latency = sum of per-row (1 ISSUE + WAIT cycles) + 1 DONE cycle + 1 accept cycle.
- `digit` and `max_score` update on the edge that samples `done_row`; they are final by the `class_done` cycle.
- `busy` = (state != IDLE).

## Structure
- Package `classifier_pkg`:
  - state enum type (IDLE, ISSUE, WAIT, DONE);
  - constants: default NUM_ROWS (10), row-index width (4), score width (16).
- Timeout counter: instantiate the existing `flex_counter`.
  - NUM_CNT_BITS=10, rollover_val=TIMEOUT_CYCLES.
  - clear = ISSUE state, count_enable = WAIT state.
  - Timeout = rollover_flag while in WAIT.
- Score register file and argmax logic live in this module; no further sub-modules.

## Test plan
- Normal pass: model returns scores 5,9,300,12,7,300,1,0,299,8 with `done_row` 20 cycles after each `begin_mult` -> exactly 10 `begin_mult` pulses with row_select 0..9; class_done once; digit=2, max_score=300 (tie keeps row 2); score_out for score_sel=5 reads 300.
- All-zero scores -> digit=0, max_score=0, class_done asserted.
- Timeout: withhold `done_row` on row 3 -> error=1 after TIMEOUT_CYCLES in WAIT; return to IDLE; no class_done; next `start` clears error.
- `start` held high through a whole pass, plus a stray `done_row` in IDLE -> no second pass begins until DONE→IDLE; the stray pulse changes nothing.
- Reset asserted in WAIT of row 4 -> all outputs take reset values within the same cycle; a fresh pass afterwards behaves like the normal case.
- `done_row` and timeout on the same cycle -> score captured, no error, sequencing continues.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared types and sizing constants for the digit classifier row sequencer.
package classifier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_NUM_ROWS = 10;
    localparam int unsigned ROW_W            = 4;
    localparam int unsigned SCORE_W          = 16;
    localparam int unsigned CNT_W            = 10;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable rollover value.
// Ports: clk, n_rst (async active-low), clear (sync, wins over enable),
//        count_enable, rollover_val, rollover_flag (registered, high while
//        the count equals rollover_val).
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;
    logic [NUM_CNT_BITS-1:0] next_count;

    // After reaching rollover_val the count restarts at 1, not 0.
    always_comb begin
        next_count = count;
        if (clear) begin
            next_count = '0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                next_count = NUM_CNT_BITS'(1);
            end else begin
                next_count = count + NUM_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count         <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count         <= next_count;
            rollover_flag <= (next_count == rollover_val);
        end
    end

endmodule

// File: rtl/digit_classifier_ctrl.sv
// Sequences the multiplier through every weight row, stores each row score
// and tracks the running argmax as the classified digit.
// Ports: clk, n_rst (async active-low), start, done_row, row_result,
//        score_sel -> begin_mult, row_select, busy, class_done, digit,
//        max_score, error (sticky timeout), score_out (combinational read).
module digit_classifier_ctrl
    import classifier_pkg::*;
#(
    parameter int unsigned      NUM_ROWS       = DEFAULT_NUM_ROWS,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 10'd1000
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               done_row,
    input  logic [SCORE_W-1:0] row_result,
    input  logic [ROW_W-1:0]   score_sel,
    output logic               begin_mult,
    output logic [ROW_W-1:0]   row_select,
    output logic               busy,
    output logic               class_done,
    output logic [ROW_W-1:0]   digit,
    output logic [SCORE_W-1:0] max_score,
    output logic               error,
    output logic [SCORE_W-1:0] score_out
);

    state_t             state;
    state_t             next_state;
    logic [ROW_W-1:0]   next_row;
    logic [ROW_W-1:0]   next_digit;
    logic [SCORE_W-1:0] next_max;
    logic               next_error;
    logic               capture;
    logic               clear_scores;
    logic               rollover_flag;
    logic               timeout;

    logic [SCORE_W-1:0] scores [NUM_ROWS];

    // Counts WAIT cycles since the last begin_mult.
    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_timeout_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state == ISSUE),
        .count_enable  (state == WAIT),
        .rollover_val  (TIMEOUT_CYCLES),
        .rollover_flag (rollover_flag)
    );

    assign timeout = (state == WAIT) && rollover_flag;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus next values of the sequencing/argmax registers.
    always_comb begin
        next_state   = state;
        next_row     = row_select;
        next_digit   = digit;
        next_max     = max_score;
        next_error   = error;
        capture      = 1'b0;
        clear_scores = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state   = ISSUE;
                    next_row     = '0;
                    next_error   = 1'b0;
                    clear_scores = 1'b1;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                // A row completion on the timeout cycle still counts.
                if (done_row) begin
                    capture = 1'b1;
                    // Strict compare keeps the lowest index on ties.
                    if ((row_select == '0) || (row_result > max_score)) begin
                        next_max   = row_result;
                        next_digit = row_select;
                    end
                    if (row_select == ROW_W'(NUM_ROWS - 1)) begin
                        next_state = DONE;
                    end else begin
                        next_row   = row_select + ROW_W'(1);
                        next_state = ISSUE;
                    end
                end else if (timeout) begin
                    next_error = 1'b1;
                    next_state = IDLE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            begin_mult <= 1'b0;
            busy       <= 1'b0;
            class_done <= 1'b0;
            row_select <= '0;
            digit      <= '0;
            max_score  <= '0;
            error      <= 1'b0;
        end else begin
            begin_mult <= (next_state == ISSUE);
            busy       <= (next_state != IDLE);
            class_done <= (next_state == DONE);
            row_select <= next_row;
            digit      <= next_digit;
            max_score  <= next_max;
            error      <= next_error;
        end
    end

    // Score register file; wiped when a pass is accepted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(NUM_ROWS); i++) begin
                scores[i] <= '0;
            end
        end else if (clear_scores) begin
            for (int i = 0; i < int'(NUM_ROWS); i++) begin
                scores[i] <= '0;
            end
        end else if (capture) begin
            scores[row_select] <= row_result;
        end
    end

    always_comb begin
        score_out = '0;
        if (int'(score_sel) < int'(NUM_ROWS)) begin
            score_out = scores[score_sel];
        end
    end

endmodule
